// File: rtl/gen_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module      : gen_reg_file_if
// Description : Control-FSM to register-file strobe/data bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface gen_reg_file_if;
    logic [1:0]  gen_sel;
    logic        gen_lr_sel;
    logic        gen_wr;
    logic        gen_oe;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        pair_ld;
    logic        pair_oe;
    logic        pair_inc;
    logic        pair_dec;
    logic [15:0] addr_in;
    logic [15:0] addr_out;
    logic        addr_oe;
    logic        op_conflict;

    modport master (
        output gen_sel, gen_lr_sel, gen_wr, gen_oe, data_in,
        output pair_ld, pair_oe, pair_inc, pair_dec, addr_in,
        input  data_out, data_oe, addr_out, addr_oe, op_conflict
    );

    modport slave (
        input  gen_sel, gen_lr_sel, gen_wr, gen_oe, data_in,
        input  pair_ld, pair_oe, pair_inc, pair_dec, addr_in,
        output data_out, data_oe, addr_out, addr_oe, op_conflict
    );
endinterface
`default_nettype wire

// File: rtl/gen_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : gen_reg_file
// Description : SM83 BC/DE/HL/SP register file with byte and pair access.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_reg_file #(
    parameter logic [15:0] BC_RST = 16'h0013,
    parameter logic [15:0] DE_RST = 16'h00D8,
    parameter logic [15:0] HL_RST = 16'h014D,
    parameter logic [15:0] SP_RST = 16'hFFFE
) (
    input  wire logic       clk,
    input  wire logic       rst,
    gen_reg_file_if.slave   bus
);

    localparam logic [1:0] c_BC = 2'd0;
    localparam logic [1:0] c_DE = 2'd1;
    localparam logic [1:0] c_HL = 2'd2;
    localparam logic [1:0] c_SP = 2'd3;

    logic [15:0] r_pair [4];
    logic [7:0]  r_data_out;
    logic        r_data_oe;
    logic        r_op_conflict;

    logic [15:0] w_sel_pair;
    logic [7:0]  w_sel_byte;
    logic [2:0]  w_op_count;

    assign w_sel_pair = r_pair[bus.gen_sel];
    assign w_sel_byte = bus.gen_lr_sel ? w_sel_pair[7:0] : w_sel_pair[15:8];
    assign w_op_count = {2'b00, bus.pair_ld} + {2'b00, bus.gen_wr}
                      + {2'b00, bus.pair_inc} + {2'b00, bus.pair_dec};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair[c_BC]  <= BC_RST;
            r_pair[c_DE]  <= DE_RST;
            r_pair[c_HL]  <= HL_RST;
            r_pair[c_SP]  <= SP_RST;
            r_data_out    <= 8'h00;
            r_data_oe     <= 1'b0;
            r_op_conflict <= 1'b0;
        end else begin
            // One op per edge; inc and dec together cancel rather than pick one.
            if (bus.pair_ld) begin
                r_pair[bus.gen_sel] <= bus.addr_in;
            end else if (bus.gen_wr) begin
                if (bus.gen_lr_sel) begin
                    r_pair[bus.gen_sel] <= {w_sel_pair[15:8], bus.data_in};
                end else begin
                    r_pair[bus.gen_sel] <= {bus.data_in, w_sel_pair[7:0]};
                end
            end else if (bus.pair_inc && !bus.pair_dec) begin
                r_pair[bus.gen_sel] <= w_sel_pair + 16'd1;
            end else if (bus.pair_dec && !bus.pair_inc) begin
                r_pair[bus.gen_sel] <= w_sel_pair - 16'd1;
            end

            // Read samples the pre-write byte, giving old-value read-during-write.
            if (bus.gen_oe) begin
                r_data_out <= w_sel_byte;
            end
            r_data_oe     <= bus.gen_oe;
            r_op_conflict <= (w_op_count >= 3'd2);
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.data_oe     = r_data_oe;
    assign bus.op_conflict = r_op_conflict;
    assign bus.addr_out    = w_sel_pair;
    assign bus.addr_oe     = bus.pair_oe;

endmodule
`default_nettype wire

// File: tb/tb_gen_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_gen_reg_file
// Description : Directed vector bench for gen_reg_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gen_reg_file;

    typedef struct {
        logic        rst;
        logic [1:0]  sel;
        logic        lr;
        logic        wr;
        logic        oe;
        logic [7:0]  din;
        logic        ld;
        logic        poe;
        logic        inc;
        logic        dec;
        logic [15:0] ain;
        logic [15:0] exp_pre;
        logic [15:0] exp_post;
        logic [7:0]  exp_dout;
        logic        exp_doe;
        logic        exp_conf;
    } vec_t;

    logic   clk;
    logic   rst;
    int     checks;
    int     errors;
    vec_t   vecs[$];

    gen_reg_file_if bus ();

    gen_reg_file dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] s, input logic l, input logic w,
                       input logic o, input logic [7:0] d, input logic ld, input logic po,
                       input logic inc, input logic dec, input logic [15:0] a,
                       input logic [15:0] pre, input logic [15:0] post,
                       input logic [7:0] dout, input logic doe, input logic conf);
        vec_t v;
        v.rst = r; v.sel = s; v.lr = l; v.wr = w; v.oe = o; v.din = d;
        v.ld = ld; v.poe = po; v.inc = inc; v.dec = dec; v.ain = a;
        v.exp_pre = pre; v.exp_post = post; v.exp_dout = dout;
        v.exp_doe = doe; v.exp_conf = conf;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        bus.gen_sel    = v.sel;
        bus.gen_lr_sel = v.lr;
        bus.gen_wr     = v.wr;
        bus.gen_oe     = v.oe;
        bus.data_in    = v.din;
        bus.pair_ld    = v.ld;
        bus.pair_oe    = v.poe;
        bus.pair_inc   = v.inc;
        bus.pair_dec   = v.dec;
        bus.addr_in    = v.ain;
    endtask

    initial begin
        vec_t idle;
        checks = 0;
        errors = 0;

        //   rst sel lr wr oe din    ld po in de ain       pre       post      dout   doe cf
        // Read all eight reset bytes
        add(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0013, 16'h0013, 8'h00, 1, 0);
        add(0, 0, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h0013, 16'h0013, 8'h13, 1, 0);
        add(0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h00D8, 16'h00D8, 8'h00, 1, 0);
        add(0, 1, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h00D8, 16'h00D8, 8'hD8, 1, 0);
        add(0, 2, 0, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h014D, 16'h014D, 8'h01, 1, 0);
        add(0, 2, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h014D, 16'h014D, 8'h4D, 1, 0);
        add(0, 3, 0, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 16'hFFFE, 8'hFF, 1, 0);
        add(0, 3, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 16'hFFFE, 8'hFE, 1, 0);
        // L write with same-edge read returns old byte, next read the new one
        add(0, 2, 1, 1, 1, 8'hA5, 0, 0, 0, 0, 16'h0000, 16'h014D, 16'h01A5, 8'h4D, 1, 0);
        add(0, 2, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h01A5, 16'h01A5, 8'hA5, 1, 0);
        add(0, 2, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h01A5, 16'h01A5, 8'hA5, 0, 0);
        // SP wrap around
        add(0, 3, 0, 0, 0, 8'h00, 1, 0, 0, 0, 16'hFFFF, 16'hFFFE, 16'hFFFF, 8'hA5, 0, 0);
        add(0, 3, 0, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 8'hA5, 0, 0);
        add(0, 3, 0, 0, 0, 8'h00, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 8'hA5, 0, 0);
        add(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 0, 16'h0000, 16'h0013, 16'h0013, 8'hA5, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h00D8, 16'h00D8, 8'hA5, 0, 0);
        add(0, 2, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h01A5, 16'h01A5, 8'hA5, 0, 0);
        // HL+ post-increment
        add(0, 2, 0, 0, 0, 8'h00, 1, 0, 0, 0, 16'hC000, 16'h01A5, 16'hC000, 8'hA5, 0, 0);
        add(0, 2, 0, 0, 0, 8'h00, 0, 1, 1, 0, 16'h0000, 16'hC000, 16'hC001, 8'hA5, 0, 0);
        // Conflicts on DE
        add(0, 1, 0, 1, 0, 8'h77, 1, 0, 1, 0, 16'h1234, 16'h00D8, 16'h1234, 8'hA5, 0, 1);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h1234, 8'hA5, 0, 0);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 1, 1, 16'h0000, 16'h1234, 16'h1234, 8'hA5, 0, 1);
        add(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h1234, 8'hA5, 0, 0);
        // BC byte writes; gen_wr outranks pair_dec
        add(0, 0, 0, 1, 0, 8'h5A, 0, 0, 0, 0, 16'h0000, 16'h0013, 16'h5A13, 8'hA5, 0, 0);
        add(0, 0, 1, 1, 0, 8'h3C, 0, 0, 0, 1, 16'h0000, 16'h5A13, 16'h5A3C, 8'hA5, 0, 1);
        // Reset overrides everything
        add(1, 0, 0, 1, 1, 8'h99, 1, 0, 0, 0, 16'h4321, 16'h5A3C, 16'h0013, 8'h00, 0, 0);
        add(0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h00D8, 16'h00D8, 8'h00, 1, 0);
        add(0, 2, 1, 0, 1, 8'h00, 0, 0, 0, 0, 16'h0000, 16'h014D, 16'h014D, 8'h4D, 1, 0);
        add(0, 3, 0, 0, 0, 8'h00, 0, 0, 0, 0, 16'h0000, 16'hFFFE, 16'hFFFE, 8'h4D, 0, 0);

        // Initial reset
        idle = vecs[0];
        idle.rst = 1'b1; idle.oe = 1'b0; idle.sel = 2'd0;
        drive(idle);
        @(posedge clk);
        #1;
        check("reset data_out", {8'h00, bus.data_out}, 16'h0000);
        check("reset data_oe", {15'd0, bus.data_oe}, 16'h0000);
        check("reset op_conflict", {15'd0, bus.op_conflict}, 16'h0000);
        check("reset BC", bus.addr_out, 16'h0013);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d addr_out pre", i), bus.addr_out, vecs[i].exp_pre);
            check($sformatf("v%0d addr_oe", i), {15'd0, bus.addr_oe}, {15'd0, vecs[i].poe});
            @(posedge clk);
            #1;
            check($sformatf("v%0d addr_out post", i), bus.addr_out, vecs[i].exp_post);
            check($sformatf("v%0d data_out", i), {8'h00, bus.data_out}, {8'h00, vecs[i].exp_dout});
            check($sformatf("v%0d data_oe", i), {15'd0, bus.data_oe}, {15'd0, vecs[i].exp_doe});
            check($sformatf("v%0d op_conflict", i), {15'd0, bus.op_conflict}, {15'd0, vecs[i].exp_conf});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gen_reg_file.md
Name: gen_reg_file

Overview:
General-purpose register file for the SM83 core, directly downstream of the control FSM. It consumes the FSM's gen_wr/gen_oe/gen_lr_sel/gen_sel strobes plus 16-bit pair strobes.
- Holds the BC, DE, HL and SP pairs.
- Sources and sinks bytes on the data path.
- Sources and sinks 16-bit pairs on the address path.
- Performs in-place pair increment/decrement for HL+/HL-, INC rr/DEC rr and stack ops.
Drive enables are exported; the top level builds the actual tristates.

Parameters:
BC_RST, 16'h0013, BC value after reset
DE_RST, 16'h00D8, DE value after reset
HL_RST, 16'h014D, HL value after reset
SP_RST, 16'hFFFE, SP value after reset

Ports:
clk  input  1  core clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high
gen_sel  input  2  pair select: 0=BC 1=DE 2=HL 3=SP
gen_lr_sel  input  1  byte select: 0=high (B/D/H/S), 1=low (C/E/L/P)
gen_wr  input  1  write data_in into selected byte
gen_oe  input  1  request selected byte onto data path
data_in  input  8  byte from data bus
data_out  output  8  registered byte read result
data_oe  output  1  registered drive enable for data_out
pair_ld  input  1  load selected pair from addr_in
pair_oe  input  1  drive selected pair onto address path
pair_inc  input  1  selected pair <= pair + 1
pair_dec  input  1  selected pair <= pair - 1
addr_in  input  16  value from address bus
addr_out  output  16  selected pair, combinational from current state
addr_oe  output  1  equals pair_oe, combinational
op_conflict  output  1  registered one-cycle flag: more than one write-class op requested

Behaviour:
- Reset (rst high at a rising edge):
  - Pairs take BC_RST/DE_RST/HL_RST/SP_RST.
  - data_out=8'h00, data_oe=0, op_conflict=0.
  - rst overrides every other input that cycle.
- Write-class ops are pair_ld, gen_wr, pair_inc and pair_dec. Priority, highest first: pair_ld > gen_wr > pair_inc > pair_dec.
  - Exactly one op is applied per edge, the highest-priority one asserted.
  - pair_inc and pair_dec together with no higher op: no change.
  - All ops target the pair chosen by gen_sel sampled on that edge.
- op_conflict is high for the one cycle following any edge where two or more write-class ops were asserted (rst excepted). It clears the next cycle.
- Arithmetic is 16-bit modulo:
  - FFFF+1 -> 0000.
  - 0000-1 -> FFFF.
  - The increment does not carry into or out of any other pair, and no flags are produced.
- gen_wr writes only the byte chosen by gen_lr_sel; the other byte of the pair is unchanged.
- Byte read has 1-cycle latency:
  - On an edge with gen_oe=1, data_out <= selected byte value before that edge's write, and data_oe <= 1.
  - On an edge with gen_oe=0, data_oe <= 0 and data_out holds its last value.
- Read during write to the same byte returns the old value; the new value is visible on the following read.
- addr_out is combinational and always shows the currently selected pair. addr_oe = pair_oe.
- Same-cycle pair_oe and pair_inc: addr_out shows the pre-increment value until the edge. This is the post-increment pattern for HL+ and stack pop.
- The block holds no internal FSM beyond the registered read stage. It never stalls and needs no handshake; the control FSM owns sequencing.
- No latches: every register is updated only in the clocked process. Outputs are never X after reset.

Test Plan:
1. Assert rst for 1 cycle, then read all 8 bytes via gen_oe -> data_out sequence 00,13,00,D8,01,4D,FF,FE, each valid 1 cycle after its request with data_oe=1.
2. gen_sel=2, gen_lr_sel=1, gen_wr, data_in=8'hA5 -> HL=01A5; a same-edge gen_oe returns 4D, the next read returns A5.
3. SP=FFFF via pair_ld (addr_in=16'hFFFF), then pair_inc -> SP=0000. Then pair_dec -> SP=FFFF. BC, DE and HL are unchanged throughout.
4. gen_sel=2, HL=C000, pair_oe and pair_inc together -> addr_out=C000 and addr_oe=1 during the cycle; HL=C001 after the edge.
5. pair_ld (addr_in=16'h1234) with gen_wr and pair_inc on DE -> DE=1234, op_conflict=1 for exactly one cycle. pair_inc with pair_dec alone -> DE unchanged, op_conflict=1.
6. rst asserted on the same edge as gen_wr/pair_ld/gen_oe after modifying BC -> all pairs return to reset values, data_oe=0, op_conflict=0.
